// File: rtl/vga_rect_fill_pkg.sv
// Shared definitions for the VGA rectangle-fill pixel source: screen geometry,
// colour type, fill FSM states and the clipping helper.
package vga_rect_fill_pkg;

  localparam int VGA_H_PIXELS = 160;
  localparam int VGA_V_PIXELS = 120;

  typedef logic [11:0] vga_color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } rect_fill_state_t;

  // Exclusive end coordinate, optionally limited to the visible edge.
  function automatic logic [8:0] clip_end(input logic [8:0] end_raw,
                                          input logic [8:0] limit,
                                          input logic       clip);
    if (clip && (end_raw > limit)) begin
      return limit;
    end else begin
      return end_raw;
    end
  endfunction

endpackage

// File: rtl/vga_rect_walker.sv
// Raster-order x/y counters for one rectangle: loaded on start, stepped on
// advance, wrapping x back to the origin column at the end of each row.
module vga_rect_walker
  import vga_rect_fill_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x_last,
  input  logic [7:0] y_last,
  output logic [7:0] x_next,
  output logic [7:0] y_next,
  output logic       last
);

  logic [7:0] x_r, y_r, x_org_r, x_last_r, y_last_r;

  // Coordinates of the pixel to present after this clock edge.
  always_comb begin
    x_next = x_r;
    y_next = y_r;
    if (start) begin
      x_next = x0;
      y_next = y0;
    end else if (advance) begin
      if (x_r == x_last_r) begin
        x_next = x_org_r;
        y_next = y_r + 8'd1;
      end else begin
        x_next = x_r + 8'd1;
        y_next = y_r;
      end
    end else begin
      x_next = x_r;
      y_next = y_r;
    end
  end

  assign last = (x_r == x_last_r) && (y_r == y_last_r);

  // Counter and rectangle-bound registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r      <= 8'd0;
      y_r      <= 8'd0;
      x_org_r  <= 8'd0;
      x_last_r <= 8'd0;
      y_last_r <= 8'd0;
    end else begin
      x_r <= x_next;
      y_r <= y_next;
      if (start) begin
        x_org_r  <= x0;
        x_last_r <= x_last;
        y_last_r <= y_last;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill pixel source feeding VGA pixel memory, one write per accepted
// transfer in raster order. Optional clipping to the screen: VGA_RECT_CLIP_EN.
module vga_rect_fill
  import vga_rect_fill_pkg::*;
#(
  parameter int          H_PIXELS  = VGA_H_PIXELS,
  parameter int          V_PIXELS  = VGA_V_PIXELS,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmdValid,
  output logic        o_cmdReady,
  input  logic [7:0]  i_x0,
  input  logic [7:0]  i_y0,
  input  logic [7:0]  i_w,
  input  logic [7:0]  i_h,
  input  vga_color_t  i_color,
  input  logic        i_abort,
  output logic        o_pxlValid,
  input  logic        i_pxlReady,
  output logic [31:0] o_pxlAddr,
  output logic [31:0] o_pxlData,
  output logic        o_busy,
  output logic        o_done
);

`ifdef VGA_RECT_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  rect_fill_state_t state_r, next_state_s;
  logic        cmd_ready_r, pxl_valid_r, busy_r, done_r;
  logic [31:0] pxl_addr_r, pxl_data_r;
  logic        accept_s, empty_s, advance_s, last_s, origin_out_s;
  logic [8:0]  x_end_s, y_end_s;
  logic [7:0]  x_last_s, y_last_s, x_next_s, y_next_s;

  // End sums are 9 bits so a rectangle may run past column/row 255 and wrap.
  assign x_end_s  = clip_end({1'b0, i_x0} + {1'b0, i_w}, 9'(H_PIXELS), CLIP_EN);
  assign y_end_s  = clip_end({1'b0, i_y0} + {1'b0, i_h}, 9'(V_PIXELS), CLIP_EN);
  assign x_last_s = 8'(x_end_s - 9'd1);
  assign y_last_s = 8'(y_end_s - 9'd1);

  assign origin_out_s = CLIP_EN && (({1'b0, i_x0} >= 9'(H_PIXELS)) ||
                                    ({1'b0, i_y0} >= 9'(V_PIXELS)));
  assign empty_s   = (i_w == 8'd0) || (i_h == 8'd0) || origin_out_s;
  assign accept_s  = i_cmdValid && cmd_ready_r && (state_r == IDLE);
  assign advance_s = (state_r == FILL) && i_pxlReady;

  vga_rect_walker u_walker (
    .clk     (i_clk),
    .reset   (i_reset),
    .start   (accept_s),
    .advance (advance_s),
    .x0      (i_x0),
    .y0      (i_y0),
    .x_last  (x_last_s),
    .y_last  (y_last_s),
    .x_next  (x_next_s),
    .y_next  (y_next_s),
    .last    (last_s)
  );

  // Next-state logic for the fill sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = empty_s ? DONE : FILL;
        end else begin
          next_state_s = IDLE;
        end
      end
      FILL: begin
        if (i_abort) begin
          next_state_s = IDLE;
        end else if (advance_s && last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = FILL;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      pxl_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pxl_addr_r  <= 32'd0;
      pxl_data_r  <= 32'd0;
    end else begin
      state_r     <= next_state_s;
      cmd_ready_r <= (next_state_s == IDLE);
      pxl_valid_r <= (next_state_s == FILL);
      busy_r      <= (next_state_s != IDLE);
      done_r      <= (next_state_s == DONE);
      if (next_state_s == FILL) begin
        pxl_addr_r <= ADDR_BASE | {16'd0, y_next_s, x_next_s};
      end
      if (accept_s) begin
        pxl_data_r <= {20'd0, i_color};
      end
    end
  end

  assign o_cmdReady = cmd_ready_r;
  assign o_pxlValid = pxl_valid_r;
  assign o_pxlAddr  = pxl_addr_r;
  assign o_pxlData  = pxl_data_r;
  assign o_busy     = busy_r;
  assign o_done     = done_r;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed self-checking bench for vga_rect_fill; expectations follow the
// VGA_RECT_CLIP_EN setting of the build.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, abort, pxl_valid, pxl_ready, busy, done;
  logic [7:0]  x0, y0, w, h;
  logic [11:0] color;
  logic [31:0] pxl_addr, pxl_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cap_addr [64];
  logic [31:0] cap_data [64];
  int          cap_n;
  bit          cap_done;

  always #5 clk = ~clk;

  vga_rect_fill dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cmdValid (cmd_valid),
    .o_cmdReady (cmd_ready),
    .i_x0       (x0),
    .i_y0       (y0),
    .i_w        (w),
    .i_h        (h),
    .i_color    (color),
    .i_abort    (abort),
    .o_pxlValid (pxl_valid),
    .i_pxlReady (pxl_ready),
    .o_pxlAddr  (pxl_addr),
    .o_pxlData  (pxl_data),
    .o_busy     (busy),
    .o_done     (done)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offers a command and returns at the falling edge just after acceptance.
  task automatic send_cmd(input logic [7:0] cx, input logic [7:0] cy,
                          input logic [7:0] cw, input logic [7:0] ch,
                          input logic [11:0] cc);
    int guard = 0;
    x0 = cx; y0 = cy; w = cw; h = ch; color = cc; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: cmdReady=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic capture(input int max_cycles);
    cap_n = 0;
    cap_done = 1'b0;
    for (int c = 0; c < max_cycles && !cap_done; c++) begin
      if (done === 1'b1) begin
        cap_done = 1'b1;
      end else begin
        if (pxl_valid === 1'b1 && pxl_ready === 1'b1 && cap_n < 64) begin
          cap_addr[cap_n] = pxl_addr;
          cap_data[cap_n] = pxl_data;
          cap_n++;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cmd_ready, pxl_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/valid/busy/done=%b required 0000", {cmd_ready, pxl_valid, busy, done});
    end
    n_checks++;
    if (pxl_addr !== 32'd0 || pxl_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h data=%h required 0", pxl_addr, pxl_data);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_tab [4];
    exp_tab = '{32'h0000_0302, 32'h0000_0303, 32'h0000_0402, 32'h0000_0403};
    pxl_ready = 1'b1;
    send_cmd(8'd2, 8'd3, 8'd2, 8'd2, 12'hF00);
    n_checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b ready=%b required 1 0", busy, cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pxl_valid !== 1'b1 || pxl_addr !== exp_tab[i] || pxl_data !== 32'h0000_0F00 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_write%0d: valid=%b addr=%h data=%h done=%b required 1 %h 00000f00 0",
                 i, pxl_valid, pxl_addr, pxl_data, done, exp_tab[i]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || pxl_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b valid=%b required 1 0", done, pxl_valid);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: done=%b ready=%b busy=%b required 0 1 0", done, cmd_ready, busy);
    end
  endtask

  task automatic test_empty();
    pxl_ready = 1'b1;
    send_cmd(8'd10, 8'd10, 8'd0, 8'd5, 12'h0F0);
    n_checks++;
    if (done !== 1'b1 || pxl_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: done=%b valid=%b required 1 0", done, pxl_valid);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || pxl_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_idle: done=%b valid=%b ready=%b required 0 0 1", done, pxl_valid, cmd_ready);
    end
  endtask

  task automatic test_stall();
    int  k = 0;
    bit  seen_done = 1'b0;
    pxl_ready = 1'b0;
    send_cmd(8'd0, 8'd0, 8'd4, 8'd1, 12'h0A5);
    for (int c = 0; c < 40 && !seen_done; c++) begin
      pxl_ready = (c % 3 == 0);
      if (done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (pxl_valid === 1'b1) begin
          n_checks++;
          if (pxl_addr !== 32'(k) || pxl_data !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL stall_hold c%0d: addr=%h data=%h required %h 000000a5", c, pxl_addr, pxl_data, 32'(k));
          end
          if (pxl_ready) k++;
        end
        tick();
      end
    end
    n_checks++;
    if (!seen_done || k != 4) begin
      n_fail++;
      $display("FAIL stall_count: done_seen=%0d writes=%0d required 1 4", seen_done, k);
    end
    pxl_ready = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    pxl_ready = 1'b1;
    send_cmd(8'd0, 8'd0, 8'd10, 8'd10, 12'h555);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (pxl_valid !== 1'b1 || pxl_addr !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL abort_fifth: valid=%b addr=%h required 1 00000004", pxl_valid, pxl_addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (pxl_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_stop: valid=%b busy=%b done=%b ready=%b required 0 0 0 1",
               pxl_valid, busy, done, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || pxl_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet%0d: done=%b valid=%b required 0 0", i, done, pxl_valid);
      end
    end
    send_cmd(8'd5, 8'd6, 8'd1, 8'd1, 12'h123);
    n_checks++;
    if (pxl_valid !== 1'b1 || pxl_addr !== 32'h0000_0605 || pxl_data !== 32'h0000_0123) begin
      n_fail++;
      $display("FAIL abort_newcmd: valid=%b addr=%h data=%h required 1 00000605 00000123",
               pxl_valid, pxl_addr, pxl_data);
    end
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_newdone: done=%b required 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    pxl_ready = 1'b1;
    send_cmd(8'd0, 8'd0, 8'd10, 8'd10, 12'h777);
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({cmd_ready, pxl_valid, busy, done} !== 4'b0000 || pxl_addr !== 32'd0 || pxl_data !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rvbd=%b addr=%h data=%h required 0000 0 0",
               {cmd_ready, pxl_valid, busy, done}, pxl_addr, pxl_data);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || pxl_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: ready=%b done=%b valid=%b required 1 0 0", cmd_ready, done, pxl_valid);
    end
  endtask

  task automatic test_clip();
    logic [31:0] exp_a [16];
    int          exp_n;
`ifdef VGA_RECT_CLIP_EN
    exp_n = 2;
    exp_a[0] = 32'h0000_779E;
    exp_a[1] = 32'h0000_779F;
`else
    exp_n = 16;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        exp_a[j*4+i] = {16'h0000, 8'(119 + j), 8'(158 + i)};
`endif
    pxl_ready = 1'b1;
    send_cmd(8'd158, 8'd119, 8'd4, 8'd4, 12'hABC);
    capture(64);
    n_checks++;
    if (!cap_done || cap_n != exp_n) begin
      n_fail++;
      $display("FAIL clip_count: done_seen=%0d writes=%0d required 1 %0d", cap_done, cap_n, exp_n);
    end
    for (int k = 0; k < exp_n && k < cap_n; k++) begin
      n_checks++;
      if (cap_addr[k] !== exp_a[k] || cap_data[k] !== 32'h0000_0ABC) begin
        n_fail++;
        $display("FAIL clip_write%0d: addr=%h data=%h required %h 00000abc", k, cap_addr[k], cap_data[k], exp_a[k]);
      end
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    int          exp_n;
    exp_a = '{32'h0000_00FE, 32'h0000_00FF, 32'h0000_0000};
`ifdef VGA_RECT_CLIP_EN
    exp_n = 0;
`else
    exp_n = 3;
`endif
    pxl_ready = 1'b1;
    send_cmd(8'd254, 8'd0, 8'd3, 8'd1, 12'h00F);
    capture(32);
    n_checks++;
    if (!cap_done || cap_n != exp_n) begin
      n_fail++;
      $display("FAIL wrap_count: done_seen=%0d writes=%0d required 1 %0d", cap_done, cap_n, exp_n);
    end
    for (int k = 0; k < exp_n && k < cap_n; k++) begin
      n_checks++;
      if (cap_addr[k] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL wrap_write%0d: addr=%h required %h", k, cap_addr[k], exp_a[k]);
      end
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; pxl_ready = 1'b0;
    x0 = 8'd0; y0 = 8'd0; w = 8'd0; h = 8'd0; color = 12'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_abort();
    test_reset_mid();
    test_clip();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
